// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receive path.
// Holds parity mode codes, receiver state encoding and the FIFO word layout.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // FIFO word is {data, parity_err, frame_err}
  localparam int FLAG_BITS = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_WAIT_HIGH
  } rx_state_t;

  function automatic int word_width(input int data_bits);
    return data_bits + FLAG_BITS;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with full/empty flags and a sticky
// overrun flag that records words dropped on a push into a full FIFO.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the word
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with runtime divisor, parity and stop-bit count,
// break detection and a FWFT receive FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_pin,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_parity_err,
  output logic                 rd_frame_err,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 break_det,
  output logic                 busy
);

  localparam int WORD_W = word_width(DATA_BITS);
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int MID    = OVERSAMPLE / 2;

  rx_state_t state, state_nx;

  logic                 rx_s1, rx_sync, rx_prev;
  logic [DIV_WIDTH-1:0] div_sh, div_eff, tick_cnt;
  logic [1:0]           par_sh;
  logic                 two_sh;
  logic [SAMP_W-1:0]    samp_cnt;
  logic                 s_m1, s_m;
  logic [DATA_BITS-1:0] data_sh;
  logic [BIT_W-1:0]     bit_idx;
  logic                 par_bit, par_err, frame_err;
  logic                 push_q, brk_q;
  logic [WORD_W-1:0]    push_word, head_word;
  logic                 tick, vote_pt, bit_end, vote, rx_fall;
  logic                 par_en, par_exp, last_bit, break_cond;
  logic                 load_sh, push_nx, brk_nx;

  assign rx_fall    = rx_prev && !rx_sync;
  assign div_eff    = (div_sh == '0) ? DIV_WIDTH'(1) : div_sh;
  assign tick       = (state != S_IDLE) && (tick_cnt == div_eff - DIV_WIDTH'(1));
  assign vote_pt    = tick && (samp_cnt == SAMP_W'(MID + 1));
  assign bit_end    = tick && (samp_cnt == SAMP_W'(OVERSAMPLE - 1));
  assign vote       = (s_m1 & s_m) | (s_m1 & rx_sync) | (s_m & rx_sync);
  assign par_en     = (par_sh == PAR_EVEN) || (par_sh == PAR_ODD);
  assign par_exp    = (^data_sh) ^ (par_sh == PAR_ODD);
  assign last_bit   = (bit_idx == BIT_W'(DATA_BITS - 1));
  assign break_cond = (data_sh == '0) && !(par_en && par_bit) && !vote;
  assign busy       = (state != S_IDLE);
  assign break_det  = brk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Completion is taken at the vote point of the last stop bit so the
  // receiver is back in IDLE before the next start edge can arrive.
  always_comb begin
    state_nx = state;
    load_sh  = 1'b0;
    push_nx  = 1'b0;
    brk_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_fall) begin
          state_nx = S_START;
          load_sh  = 1'b1;
        end
      end
      S_START: begin
        if (vote_pt && vote)  state_nx = S_IDLE;
        else if (bit_end)     state_nx = S_DATA;
      end
      S_DATA: begin
        if (bit_end && last_bit) state_nx = par_en ? S_PARITY : S_STOP1;
      end
      S_PARITY: begin
        if (bit_end) state_nx = S_STOP1;
      end
      S_STOP1: begin
        if (vote_pt && break_cond) begin
          state_nx = S_WAIT_HIGH;
          brk_nx   = 1'b1;
        end else if (vote_pt && !two_sh) begin
          state_nx = S_IDLE;
          push_nx  = 1'b1;
        end else if (bit_end) begin
          state_nx = S_STOP2;
        end
      end
      S_STOP2: begin
        if (vote_pt) begin
          state_nx = S_IDLE;
          push_nx  = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      div_sh    <= '0;
      par_sh    <= PAR_NONE;
      two_sh    <= 1'b0;
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      s_m1      <= 1'b1;
      s_m       <= 1'b1;
      data_sh   <= '0;
      bit_idx   <= '0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
      brk_q     <= 1'b0;
    end else begin
      rx_s1   <= rx_pin;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
      push_q  <= push_nx;
      brk_q   <= brk_nx;
      if (load_sh) begin
        div_sh    <= divisor;
        par_sh    <= parity_mode;
        two_sh    <= two_stop;
        bit_idx   <= '0;
        par_bit   <= 1'b0;
        par_err   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (state == S_IDLE || tick) tick_cnt <= '0;
      else                         tick_cnt <= tick_cnt + DIV_WIDTH'(1);
      if (state == S_IDLE) begin
        samp_cnt <= '0;
      end else if (tick) begin
        samp_cnt <= bit_end ? '0 : samp_cnt + SAMP_W'(1);
      end
      if (tick && samp_cnt == SAMP_W'(MID - 1)) s_m1 <= rx_sync;
      if (tick && samp_cnt == SAMP_W'(MID))     s_m  <= rx_sync;
      if (state == S_DATA && vote_pt) data_sh <= {vote, data_sh[DATA_BITS-1:1]};
      if (state == S_DATA && bit_end) bit_idx <= bit_idx + BIT_W'(1);
      if (state == S_PARITY && vote_pt) begin
        par_bit <= vote;
        par_err <= vote ^ par_exp;
      end
      if (state == S_STOP1 && vote_pt) frame_err <= ~vote;
      if (push_nx) push_word <= {data_sh, par_err, frame_err | ~vote};
    end
  end

  uart_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push_q),
    .push_data   (push_word),
    .pop         (rd_en),
    .overrun_clr (overrun_clr),
    .head        (head_word),
    .empty       (rx_empty),
    .full        (rx_full),
    .overrun     (overrun)
  );

  assign rd_data       = head_word[WORD_W-1:FLAG_BITS];
  assign rd_parity_err = head_word[1];
  assign rd_frame_err  = head_word[0];

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param against a frame-level
// reference model (expected words derived from the bits put on the line).
module tb_uart_rx_param;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] divisor;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        rx_pin;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_parity_err;
  logic        rd_frame_err;
  logic        rx_empty;
  logic        rx_full;
  logic        overrun;
  logic        overrun_clr;
  logic        break_det;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q [$];

  always #10 clk = ~clk;

  uart_rx_param #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS),
    .DIV_WIDTH  (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .divisor       (divisor),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .rx_pin        (rx_pin),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_parity_err (rd_parity_err),
    .rd_frame_err  (rd_frame_err),
    .rx_empty      (rx_empty),
    .rx_full       (rx_full),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .break_det     (break_det),
    .busy          (busy)
  );

  function automatic int bit_clocks(input int div);
    return OS * ((div == 0) ? 1 : div);
  endfunction

  // Expected {data, parity_err, frame_err} from what was put on the wire.
  function automatic logic [9:0] model_word(input logic [7:0] d, input logic [1:0] pm,
                                            input logic two, input logic pb,
                                            input logic s1, input logic s2);
    int   ones;
    logic pe;
    logic fe;
    ones = $countones(d);
    pe   = 1'b0;
    if (pm == 2'b01) pe = ((ones + int'(pb)) % 2) != 0;
    if (pm == 2'b10) pe = ((ones + int'(pb)) % 2) == 0;
    fe = !s1 || (two && !s2);
    return {d, pe, fe};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic two,
                            input int div, input logic pb, input logic s1, input logic s2,
                            input logic scramble);
    int   bt;
    logic last_stop;
    bt          = bit_clocks(div);
    divisor     = 16'(div);
    parity_mode = pm;
    two_stop    = two;
    rx_pin      = 1'b0;
    repeat (bt) @(negedge clk);
    if (scramble) begin
      divisor     = 16'($urandom_range(1, 9));
      parity_mode = 2'($urandom);
      two_stop    = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (bt) @(negedge clk);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      rx_pin = pb;
      repeat (bt) @(negedge clk);
    end
    rx_pin = s1;
    repeat (bt) @(negedge clk);
    last_stop = s1;
    if (two) begin
      rx_pin = s2;
      repeat (bt) @(negedge clk);
      last_stop = s2;
    end
    rx_pin = 1'b1;
    if (!last_stop) repeat (bt) @(negedge clk);
  endtask

  task automatic read_head(output logic [10:0] w);
    w     = {rx_empty, rd_data, rd_parity_err, rd_frame_err};
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] obs;
    repeat (3) @(negedge clk);
    obs = {rd_data, rd_parity_err, rd_frame_err, rx_empty, rx_full, overrun, break_det, busy};
    checks++;
    if (obs !== 15'b00000000_0010000) begin
      failures++;
      $display("FAIL reset_held: got %b expected %b", obs, 15'b00000000_0010000);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    obs = {rd_data, rd_parity_err, rd_frame_err, rx_empty, rx_full, overrun, break_det, busy};
    checks++;
    if (obs !== 15'b00000000_0010000) begin
      failures++;
      $display("FAIL reset_release: got %b expected %b", obs, 15'b00000000_0010000);
    end
  endtask

  task automatic test_basic;
    logic [7:0]  d;
    logic [10:0] w;
    int          bt;
    d           = 8'h55;
    divisor     = 16'd27;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    bt          = bit_clocks(27);
    rx_pin      = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (bt) @(negedge clk);
    end
    checks++;
    if ({rx_empty, busy} !== 2'b11) begin
      failures++;
      $display("FAIL basic_before_stop: empty,busy=%b expected 11", {rx_empty, busy});
    end
    rx_pin = 1'b1;
    repeat (bt) @(negedge clk);
    checks++;
    if ({rx_empty, busy} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after_stop: empty,busy=%b expected 00", {rx_empty, busy});
    end
    read_head(w);
    checks++;
    if (w !== {1'b0, model_word(d, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1)}) begin
      failures++;
      $display("FAIL basic_word: got %h expected %h", w, {1'b0, 8'h55, 2'b00});
    end
    checks++;
    if (rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL basic_pop_empty: rx_empty=%b expected 1", rx_empty);
    end
  endtask

  task automatic test_parity;
    logic [10:0] w;
    logic [9:0]  e;
    logic [7:0]  d;
    logic        pb;
    send_frame(8'hA3, 2'b01, 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    read_head(w);
    checks++;
    if (w !== {1'b0, 8'hA3, 2'b10}) begin
      failures++;
      $display("FAIL parity_even_bad: got %h expected %h", w, {1'b0, 8'hA3, 2'b10});
    end
    send_frame(8'hA3, 2'b01, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    read_head(w);
    checks++;
    if (w !== {1'b0, 8'hA3, 2'b00}) begin
      failures++;
      $display("FAIL parity_even_good: got %h expected %h", w, {1'b0, 8'hA3, 2'b00});
    end
    for (int k = 0; k < 2; k++) begin
      d  = 8'($urandom);
      pb = 1'(k);
      e  = model_word(d, 2'b10, 1'b0, pb, 1'b1, 1'b1);
      send_frame(d, 2'b10, 1'b0, 2, pb, 1'b1, 1'b1, 1'b0);
      read_head(w);
      checks++;
      if (w !== {1'b0, e}) begin
        failures++;
        $display("FAIL parity_odd_%0d: got %h expected %h", k, w, {1'b0, e});
      end
    end
  endtask

  task automatic test_glitch;
    logic busy_seen;
    int   waited;
    divisor     = 16'd27;
    parity_mode = 2'b00;
    busy_seen   = 1'b0;
    rx_pin      = 1'b0;
    repeat (135) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    rx_pin = 1'b1;
    waited = 0;
    while (busy && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_pulse: busy seen=%b expected 1", busy_seen);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy_timeout: busy=%b expected 0 within 3000 clocks", busy);
    end
    repeat (500) @(negedge clk);
    checks++;
    if ({rx_empty, busy} !== 2'b10) begin
      failures++;
      $display("FAIL glitch_no_word: empty,busy=%b expected 10", {rx_empty, busy});
    end
  endtask

  task automatic test_overrun;
    logic [10:0] w;
    logic [9:0]  e;
    logic        exp_ovr;
    exp_ovr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 2'b00, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
      if (exp_q.size() < 8) exp_q.push_back(model_word(8'(k), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
      else                  exp_ovr = 1'b1;
      if (k >= 7) begin
        checks++;
        if ({rx_full, overrun} !== {exp_q.size() == 8, exp_ovr}) begin
          failures++;
          $display("FAIL overrun_fill_%0d: full,overrun=%b expected %b", k,
                   {rx_full, overrun}, {exp_q.size() == 8, exp_ovr});
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      read_head(w);
      checks++;
      if (w !== {1'b0, e}) begin
        failures++;
        $display("FAIL overrun_read_%0d: got %h expected %h", k, w, {1'b0, e});
      end
    end
    checks++;
    if ({rx_empty, overrun} !== 2'b11) begin
      failures++;
      $display("FAIL overrun_drained: empty,overrun=%b expected 11", {rx_empty, overrun});
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr: overrun=%b expected 0", overrun);
    end
  endtask

  task automatic test_break;
    int          pulses;
    int          bt;
    logic [10:0] w;
    bt          = bit_clocks(2);
    divisor     = 16'd2;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    pulses      = 0;
    rx_pin      = 1'b0;
    repeat (12 * bt) begin
      @(negedge clk);
      if (break_det) pulses++;
    end
    rx_pin = 1'b1;
    repeat (2 * bt) begin
      @(negedge clk);
      if (break_det) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL break_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if ({rx_empty, busy} !== 2'b10) begin
      failures++;
      $display("FAIL break_no_push: empty,busy=%b expected 10", {rx_empty, busy});
    end
    send_frame(8'h3C, 2'b00, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    read_head(w);
    checks++;
    if (w !== {1'b0, 8'h3C, 2'b00}) begin
      failures++;
      $display("FAIL break_resync: got %h expected %h", w, {1'b0, 8'h3C, 2'b00});
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0]  d;
    logic [14:0] obs;
    logic [10:0] w;
    int          bt;
    send_frame(8'h11, 2'b00, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    d      = 8'h96;
    bt     = bit_clocks(2);
    rx_pin = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_pin = d[i];
      repeat (bt) @(negedge clk);
    end
    rx_pin = d[4];
    repeat (bt / 2) @(negedge clk);
    checks++;
    if ({rx_empty, busy} !== 2'b01) begin
      failures++;
      $display("FAIL midreset_pre: empty,busy=%b expected 01", {rx_empty, busy});
    end
    reset  = 1'b1;
    rx_pin = 1'b1;
    @(negedge clk);
    obs = {rd_data, rd_parity_err, rd_frame_err, rx_empty, rx_full, overrun, break_det, busy};
    checks++;
    if (obs !== 15'b00000000_0010000) begin
      failures++;
      $display("FAIL midreset_values: got %b expected %b", obs, 15'b00000000_0010000);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * bt) @(negedge clk);
    checks++;
    if ({rx_empty, busy} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_idle: empty,busy=%b expected 10", {rx_empty, busy});
    end
    send_frame(8'hC5, 2'b00, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    read_head(w);
    checks++;
    if (w !== {1'b0, 8'hC5, 2'b00}) begin
      failures++;
      $display("FAIL midreset_next: got %h expected %h", w, {1'b0, 8'hC5, 2'b00});
    end
  endtask

  task automatic test_two_stop;
    logic [10:0] w;
    logic [9:0]  e;
    for (int k = 0; k < 2; k++) begin
      e = model_word(8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 1'(k));
      send_frame(8'h5A, 2'b00, 1'b1, 1, 1'b0, 1'b1, 1'(k), 1'b0);
      read_head(w);
      checks++;
      if (w !== {1'b0, e}) begin
        failures++;
        $display("FAIL two_stop_s2_%0d: got %h expected %h", k, w, {1'b0, e});
      end
    end
  endtask

  task automatic test_random;
    logic [7:0]  d;
    logic [1:0]  pm;
    logic        two, pb, s1, s2;
    int          div, n;
    logic [10:0] w;
    logic [9:0]  e;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        d   = 8'($urandom);
        pm  = 2'($urandom);
        two = 1'($urandom);
        pb  = 1'($urandom);
        div = $urandom_range(0, 3);
        s1  = ($urandom_range(0, 4) != 0);
        s2  = ($urandom_range(0, 4) != 0);
        if (d == 8'h00) s1 = 1'b1;
        send_frame(d, pm, two, div, pb, s1, s2, 1'b1);
        exp_q.push_back(model_word(d, pm, two, pb, s1, s2));
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        read_head(w);
        checks++;
        if (w !== {1'b0, e}) begin
          failures++;
          $display("FAIL random_r%0d: got %h expected %h", r, w, {1'b0, e});
        end
      end
      checks++;
      if (rx_empty !== 1'b1) begin
        failures++;
        $display("FAIL random_drain_r%0d: rx_empty=%b expected 1", r, rx_empty);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    rx_pin      = 1'b1;
    rd_en       = 1'b0;
    overrun_clr = 1'b0;
    divisor     = 16'd27;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_overrun();
    test_break();
    test_reset_mid();
    test_two_stop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
